// File: rtl/uart_rx_fifo_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo_pkg
// Shared definitions for the uart receive buffer and its I/O decode:
//   - memory-mapped register addresses (data / status)
//   - status word bit positions
//   - ingest FSM state encoding
//   - pack_status(): assembles the 16-bit status word
// ----------------------------------------------------------------------------
package uart_rx_fifo_pkg;

  // I/O decode addresses of the receive buffer registers.
  localparam logic [15:0] UART_DATA_ADDR = 16'h0001;
  localparam logic [15:0] UART_STAT_ADDR = 16'h0002;

  // Status word layout: {ovf, full, empty, 5'b0, count[7:0]}.
  localparam int STAT_OVF   = 15;
  localparam int STAT_FULL  = 14;
  localparam int STAT_EMPTY = 13;

  // Ingest FSM: one byte per rx_new high period, acknowledged exactly once.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } ingest_state_t;

  function automatic logic [15:0] pack_status(input logic       ovf,
                                              input logic       full,
                                              input logic       empty,
                                              input logic [7:0] count);
    logic [15:0] s;
    s             = '0;
    s[STAT_OVF]   = ovf;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    s[7:0]        = count;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO, 2**DEPTH_LOG2 entries of WIDTH bits. Reusable by any
// receive buffer (uart now, spi later).
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (pointers/count only)
//   push     in   write wr_data; accepted when not full, or when a pop
//                 happens in the same cycle
//   pop      in   remove head; ignored when empty
//   wr_data  in   WIDTH   data to write
//   full     out  count == depth
//   empty    out  count == 0
//   count    out  DEPTH_LOG2+1 bits, current occupancy
//   head     out  WIDTH   oldest entry (undefined when empty)
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [WIDTH-1:0]      head
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = CNT_ONE[DEPTH_LOG2-1:0];

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  pop_ok;
  logic                  push_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_FULL);
  assign count   = cnt;
  assign head    = mem[rd_ptr];

  // A pop on a full FIFO frees the slot the simultaneous push writes into.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; empty/count already mask stale
  // entries and a resettable array would stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer between the uart receiver and the CPU I/O decode.
// Synchronises the uart's rx_new level, ingests one byte per high period,
// queues it in sync_fifo and presents registered head/status words.
//   cpu_clk  in   sole clock, rising edge
//   rst      in   synchronous active-high reset
//   rx_data  in   8   byte from uart, stable while rx_new high
//   rx_new   in   uart byte-available level (asynchronous to cpu_clk)
//   rx_ack   out  one-cycle acknowledge per accepted (or dropped) byte
//   pop      in   data-register read-done strobe; removes head
//   clr_ovf  in   status-register write strobe; clears overflow flag
//   rd_data  out  8   head byte, 8'h00 when empty (registered)
//   status   out  16  {ovf, full, empty, 5'b0, count[7:0]} (registered)
//   irq      out  occupancy interrupt
// Build option: define RXFIFO_IRQ_EN to drive irq = registered
// (count >= IRQ_LEVEL); otherwise irq is tied low.
// ----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int IRQ_LEVEL   = 1
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_new,
  output logic        rx_ack,
  input  logic        pop,
  input  logic        clr_ovf,
  output logic [7:0]  rd_data,
  output logic [15:0] status,
  output logic        irq
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_rx_fifo: SYNC_STAGES must be >= 2");
  end
  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 7) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH_LOG2 must be 1..7 to fit the 8-bit count field");
  end
  if (IRQ_LEVEL < 1 || IRQ_LEVEL > (1 << DEPTH_LOG2)) begin : g_bad_irq
    $error("uart_rx_fifo: IRQ_LEVEL must be 1..2**DEPTH_LOG2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rn_s;
  ingest_state_t          state_q;
  ingest_state_t          state_d;
  logic                   fifo_push;
  logic                   ovf_set;
  logic                   ovf_q;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DEPTH_LOG2:0]    fifo_count;
  logic [7:0]             fifo_head;
  logic [7:0]             rd_data_q;
  logic                   full_q;
  logic                   empty_q;
  logic [7:0]             count_q;

  // rx_new crosses clock domains; only the last stage is used.
  always_ff @(posedge cpu_clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_new};
  end
  assign rn_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge cpu_clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned and a latch is never inferred.
  always_comb begin
    state_d   = state_q;
    fifo_push = 1'b0;
    ovf_set   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rn_s) begin
          fifo_push = 1'b1;
          // A full FIFO drops the byte unless a pop frees a slot this cycle.
          ovf_set   = fifo_full && !pop;
          state_d   = ST_ACK;
        end
      end
      ST_ACK:      state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!rn_s) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // The ACK state lasts exactly one cycle, so the acknowledge is a clean
  // registered pulse.
  assign rx_ack = (state_q == ST_ACK);

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (cpu_clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (pop),
    .wr_data (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    (fifo_head)
  );

  // Set wins over clear so an overflow in the clearing cycle is not lost.
  always_ff @(posedge cpu_clk) begin
    if (rst)          ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
    else if (clr_ovf) ovf_q <= 1'b0;
  end

  // Registered bus-facing copies: no combinational path from pop to outputs.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      rd_data_q <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      count_q   <= '0;
    end else begin
      rd_data_q <= fifo_empty ? 8'h00 : fifo_head;
      full_q    <= fifo_full;
      empty_q   <= fifo_empty;
      count_q   <= 8'(fifo_count);
    end
  end

  assign rd_data = rd_data_q;
  assign status  = pack_status(ovf_q, full_q, empty_q, count_q);

`ifdef RXFIFO_IRQ_EN
  localparam logic [DEPTH_LOG2:0] IRQ_THRESH = (DEPTH_LOG2 + 1)'(IRQ_LEVEL);
  logic irq_q;

  always_ff @(posedge cpu_clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= (fifo_count >= IRQ_THRESH);
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo (DEPTH_LOG2=4, SYNC_STAGES=2, IRQ_LEVEL=4).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// irq expectations follow the RXFIFO_IRQ_EN build option.
// ----------------------------------------------------------------------------
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  localparam int SYNC = 2;

`ifdef RXFIFO_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        cpu_clk = 1'b0;
  logic        rst     = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_new  = 1'b0;
  logic        rx_ack;
  logic        pop     = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [7:0]  rd_data;
  logic [15:0] status;
  logic        irq;

  int checks  = 0;
  int errors  = 0;
  int ack_cnt = 0;

  uart_rx_fifo #(
    .DEPTH_LOG2  (4),
    .SYNC_STAGES (SYNC),
    .IRQ_LEVEL   (4)
  ) dut (
    .cpu_clk (cpu_clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_new  (rx_new),
    .rx_ack  (rx_ack),
    .pop     (pop),
    .clr_ovf (clr_ovf),
    .rd_data (rd_data),
    .status  (status),
    .irq     (irq)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Counts acknowledge cycles so duplicate acks are caught.
  always @(negedge cpu_clk) if (rx_ack) ack_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge cpu_clk);
  endtask

  // Full uart handshake for one byte; returns at a falling edge with the FSM
  // back in IDLE and the registered outputs settled.
  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data = b;
    rx_new  = 1'b1;
    n = 0;
    while (!rx_ack && n < 20) begin
      @(negedge cpu_clk);
      n++;
    end
    check($sformatf("ack_seen_%02h", b), 32'(rx_ack), 32'd1);
    rx_new = 1'b0;
    tick(6);
  endtask

  // One-cycle pop; returns once rd_data shows the new head.
  task automatic do_pop();
    pop = 1'b1;
    @(negedge cpu_clk);
    pop = 1'b0;
    @(negedge cpu_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int a0;
    logic [7:0] exp_b;

    $display("uart_rx_fifo bench: data reg %h, status reg %h", UART_DATA_ADDR, UART_STAT_ADDR);

    // Reset values
    @(negedge cpu_clk);
    tick(2);
    check("rst_ack",    32'(rx_ack),  32'd0);
    check("rst_status", 32'(status),  32'h2000);
    check("rst_rd",     32'(rd_data), 32'h00);
    check("rst_irq",    32'(irq),     32'd0);
    rst = 1'b0;
    tick(2);

    // 1: long rx_new high -> exactly one ack, SYNC+1 cycles after rise
    a0 = ack_cnt;
    lat = 0;
    rx_data = 8'h41;
    rx_new  = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge cpu_clk);
      if (rx_ack && lat == 0) lat = i;
    end
    rx_new = 1'b0;
    tick(6);
    check("t1_latency", 32'(lat), 32'(SYNC + 1));
    check("t1_acks",    32'(ack_cnt - a0), 32'd1);
    check("t1_status",  32'(status),  32'h0001);
    check("t1_rd",      32'(rd_data), 32'h41);
    do_pop();
    check("t1_empty",   32'(status),  32'h2000);

    // 2: fill 16, overflow on 17th, drain in order
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    check("t2_full",   32'(status),  32'h4010);
    check("t2_head",   32'(rd_data), 32'h01);
    a0 = ack_cnt;
    send_byte(8'hAA);
    check("t2_ovf_ack", 32'(ack_cnt - a0), 32'd1);
    check("t2_ovf",     32'(status),  32'hC010);
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("t2_pop%0d", k), 32'(rd_data), 32'(k));
      do_pop();
    end
    check("t2_drained", 32'(status),  32'hA000);
    check("t2_rd_zero", 32'(rd_data), 32'h00);

    // 4: clr_ovf, then pop while empty, then pointer sanity
    clr_ovf = 1'b1;
    @(negedge cpu_clk);
    clr_ovf = 1'b0;
    check("t4_clr_ovf", 32'(status), 32'h2000);
    do_pop();
    check("t4_pop_empty_st", 32'(status),  32'h2000);
    check("t4_pop_empty_rd", 32'(rd_data), 32'h00);
    send_byte(8'h5A);
    check("t4_after_st", 32'(status),  32'h0001);
    check("t4_after_rd", 32'(rd_data), 32'h5A);
    do_pop();

    // 3: full FIFO, pop lands on the same edge as the 17th push
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    check("t3_full", 32'(status), 32'h4010);
    a0 = ack_cnt;
    rx_data = 8'hAA;
    rx_new  = 1'b1;
    tick(SYNC);            // rn_s now high; push happens on the next edge
    pop = 1'b1;
    @(negedge cpu_clk);
    pop = 1'b0;
    check("t3_ack_align", 32'(rx_ack), 32'd1);
    rx_new = 1'b0;
    tick(6);
    check("t3_acks",   32'(ack_cnt - a0), 32'd1);
    check("t3_status", 32'(status), 32'h4010);
    for (int k = 0; k < 16; k++) begin
      exp_b = (k < 15) ? 8'(k + 2) : 8'hAA;
      check($sformatf("t3_pop%0d", k), 32'(rd_data), 32'(exp_b));
      do_pop();
    end
    check("t3_drained", 32'(status), 32'h2000);

    // 5: reset during WAIT_LOW with rx_new held high
    rx_data = 8'h55;
    rx_new  = 1'b1;
    lat = 0;
    while (!rx_ack && lat < 20) begin
      @(negedge cpu_clk);
      lat++;
    end
    check("t5_first_ack", 32'(rx_ack), 32'd1);
    tick(3);
    rst = 1'b1;
    tick(2);
    check("t5_rst_ack",    32'(rx_ack),  32'd0);
    check("t5_rst_status", 32'(status),  32'h2000);
    check("t5_rst_rd",     32'(rd_data), 32'h00);
    check("t5_rst_irq",    32'(irq),     32'd0);
    a0 = ack_cnt;
    rst = 1'b0;
    tick(12);
    check("t5_reaccept", 32'(ack_cnt - a0), 32'd1);
    check("t5_status",   32'(status),  32'h0001);
    check("t5_rd",       32'(rd_data), 32'h55);
    rx_new = 1'b0;
    tick(6);
    do_pop();

    // 6: occupancy interrupt at IRQ_LEVEL=4
    for (int i = 0; i < 3; i++) send_byte(8'(8'h60 + i));
    check("t6_cnt3",  32'(status), 32'h0003);
    check("t6_irq3",  32'(irq),    32'd0);
    send_byte(8'h63);
    check("t6_cnt4",  32'(status), 32'h0004);
    check("t6_irq4",  32'(irq),    32'(IRQ_ON));
    do_pop();
    check("t6_pop_cnt", 32'(status), 32'h0003);
    check("t6_pop_irq", 32'(irq),    32'd0);
    for (int i = 0; i < 3; i++) do_pop();
    check("t6_drained", 32'(status), 32'h2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
